// File: rtl/prod_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
// Optional saturation build: define PROD_ACC_SAT_EN.
package prod_acc_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_ACC_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } prod_acc_state_t;

endpackage

// File: rtl/prod_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product.
// Under PROD_ACC_SAT_EN the result clamps at all-ones and reports the clamp.
module prod_acc_add #(
    parameter int ACC_W  = 11,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum
`ifdef PROD_ACC_SAT_EN
    ,
    output logic              clamped
`endif
);

`ifdef PROD_ACC_SAT_EN
    logic [ACC_W:0] full;

    // The carry-out of a one-bit-wider add is exactly the overflow condition.
    assign full    = {1'b0, a} + (ACC_W+1)'(b);
    assign clamped = full[ACC_W];
    assign sum     = clamped ? '1 : full[ACC_W-1:0];
`else
    assign sum = a + ACC_W'(b);
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Sums a batch of unsigned products from a valid/ready stream and holds the
// total on a valid/ready output. Saturating build: define PROD_ACC_SAT_EN.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy
`ifdef PROD_ACC_SAT_EN
    ,
    output logic              ovf
`endif
);

    prod_acc_state_t  state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] add_sum;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             start_ok;
    logic             accept;
    logic             last_beat;

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign accept    = (state_q == ST_ACCUM) && in_valid;
    assign last_beat = accept && (LEN_W'(cnt_q + 1'b1) == len_q);

`ifdef PROD_ACC_SAT_EN
    logic add_clamped;
    logic ovf_q;

    prod_acc_add #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .a       (acc_q),
        .b       (in_prod),
        .sum     (add_sum),
        .clamped (add_clamped)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            ovf_q <= 1'b0;
        end else if (accept && add_clamped) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    prod_acc_add #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .a   (acc_q),
        .b   (in_prod),
        .sum (add_sum)
    );
`endif

    // NOTE: every output and next-state signal gets a default before the case
    // so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q <= len;
                cnt_q <= '0;
                acc_q <= '0;
            end else if (accept) begin
                cnt_q <= LEN_W'(cnt_q + 1'b1);
                acc_q <= add_sum;
            end
        end
    end

    // The accumulator is frozen outside ACCUM, so it doubles as the held result.
    assign out_sum = acc_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Downstream consumer of the `r_multiplier` product path. It accepts a batch of 8-bit products over a valid/ready stream and sums them in an accumulator. When the batch completes, it presents the total on a held valid/ready output. This block is the reduction stage that turns a series of ROM×ROM products into one dot-product-style result.

## Interface
Parameters:
- `PROD_W`, 8, product width; matches the multiplier output.
- `LEN_W`, 4, width of the batch-length input; maximum batch is 2^LEN_W−1 products.
- `ACC_W`, 11, accumulator and result width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `start`  in  1  one-cycle request to begin a batch; honoured only in IDLE.
- `len`  in  LEN_W  number of products in the batch; sampled on an accepted `start`.
- `in_valid`  in  1  `in_prod` is valid this cycle.
- `in_ready`  out  1  the block accepts a product this cycle.
- `in_prod`  in  PROD_W  product value, unsigned.
- `out_valid`  out  1  `out_sum` holds a completed batch result.
- `out_ready`  in  1  the consumer takes the result.
- `out_sum`  out  ACC_W  accumulated total, unsigned.
- `busy`  out  1  high in every state except IDLE.
- `ovf`  out  1  saturation flag; present only when `PROD_ACC_SAT_EN` is defined.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0 and `out_valid`=0.
  - When `start`=1: latch `len`, clear the accumulator and the beat counter, set `ovf`=0.
  - If `len`≠0, go to ACCUM. If `len`=0, go directly to DONE with `out_sum`=0.
- **ACCUM**
  - `in_ready`=1.
  - A product is accepted on a cycle with `in_valid`&&`in_ready`. Each accepted product does acc ← acc + zero-extend(`in_prod`) and increments the beat counter.
  - The accepted product that makes the beat count equal the latched length sends the FSM to DONE.
  - `start` is ignored in ACCUM.
- **DONE**
  - `out_valid`=1 and `in_ready`=0.
  - `out_sum` equals the accumulator and is held stable until `out_ready`=1.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `start` is ignored in DONE, including in the handshake cycle.
- Arithmetic is unsigned, modulo 2^ACC_W unless saturation is compiled in.
- With the default parameters the worst case is 15×255 = 3825. This exceeds 2^11−1, so wrap is reachable.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `out_valid`=0, `out_sum`=0, `busy`=0, `ovf`=0.
- Accepted `start` at edge N: `busy`=1 and `in_ready`=1 from cycle N+1 (`len`≠0).
- Last product accepted at edge M: `out_valid`=1 and the final `out_sum` are both visible in cycle M+1. Latency is 1 cycle.
- `len`=0: `out_valid`=1 one cycle after `start`.
- Throughput is one product per cycle; `in_valid` may be held continuously.
- `out_valid` stays high indefinitely while `out_ready`=0.
- `rst` asserted mid-batch: all outputs return to reset values asynchronously, the partial sum is discarded, and no `out_valid` is produced.

## Configuration
- `PROD_ACC_SAT_EN` defined:
  - The adder clamps at 2^ACC_W−1.
  - `ovf` goes to 1 on the first clamped addition and holds until the next accepted `start` or reset.
- Not defined:
  - The sum wraps modulo 2^ACC_W.
  - The `ovf` port does not exist.

## Structure
- Package `prod_acc_pkg` holds:
  - the state enum `prod_acc_state_t` (IDLE, ACCUM, DONE);
  - the default constants PROD_W=8, LEN_W=4, ACC_W=11.
- One sub-module, `prod_acc_add`: a combinational ACC_W-bit adder.
  - Its saturating path and carry-out are compiled under `PROD_ACC_SAT_EN`.
- The top level holds the FSM, the beat counter, the length register and the output register.

## Test plan
- Reset, then `start` with `len`=3, then products 72, 56, 13 on consecutive cycles → `out_valid`=1 one cycle after the 13 is accepted, `out_sum`=141. `out_ready`=1 → IDLE, `busy`=0.
- Same batch with `in_valid` gaps of 2 cycles and `out_ready` held 0 for 5 cycles → `in_ready` stays 1 through the gaps, `out_sum`=141, and `out_valid` holds stable for all 5 cycles.
- `start` with `len`=0 → `out_valid`=1 next cycle with `out_sum`=0. A `start` pulsed during DONE is ignored.
- `start` with `len`=15, then 15 products of 255:
  - without `PROD_ACC_SAT_EN` → `out_sum`=3825 mod 2048 = 1777;
  - with it → `out_sum`=2047 and `ovf`=1.
- `rst`=0 asserted after 2 of 3 products → `in_ready`, `busy` and `out_sum` drop to 0 immediately. A new batch of 12, 6 then yields `out_sum`=18.
- `in_valid`=1 with `in_prod`=99 while in IDLE → no acceptance. A following `start` with `len`=1 plus product 5 → `out_sum`=5.
